// File: rtl/seq_pkg.sv
// Shared definitions for the parameterised serial sequence detector.
package seq_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } seq_state_t;

    localparam logic OVERLAP_ON  = 1'b1;
    localparam logic OVERLAP_OFF = 1'b0;

    // Fill-counter width able to hold the value pattern_w itself.
    function automatic int unsigned fill_width(input int unsigned pattern_w);
        return $clog2(pattern_w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Data, control and result signals of the sequence detector.
interface seq_detect_param_if #(
    parameter int unsigned PATTERN_W = 4,
    parameter int unsigned COUNT_W   = 8
);
    logic                 en;
    logic                 w;
    logic                 clear;
    logic [PATTERN_W-1:0] pattern;
    logic                 overlap;
    logic                 out;
    logic [COUNT_W-1:0]   match_count;

    modport master (
        output en, w, clear, pattern, overlap,
        input  out, match_count
    );

    modport slave (
        input  en, w, clear, pattern, overlap,
        output out, match_count
    );
endinterface

// File: rtl/seq_shreg.sv
// Left-shifting history register; new bit enters at the LSB.
module seq_shreg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end
endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with overlap mode and saturating match counter.
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int unsigned          PATTERN_W   = 4,
    parameter int unsigned          COUNT_W     = 8,
    parameter logic [PATTERN_W-1:0] PATTERN_RST = PATTERN_W'(4'b1011)
) (
    input logic               clk,
    input logic               rst_n,
    seq_detect_param_if.slave bus
);
    localparam int unsigned          FILL_W   = fill_width(PATTERN_W);
    localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PATTERN_W);

    seq_state_t           state_q, state_next;
    logic [FILL_W-1:0]    fill_q, fill_next, fill_post;
    logic [PATTERN_W-1:0] hist, hist_post;
    logic [PATTERN_W-1:0] pat_q;
    logic [COUNT_W-1:0]   cnt_q;
    logic                 out_q;
    logic                 match;

    seq_shreg #(.WIDTH(PATTERN_W)) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .clr   (bus.clear),
        .din   (bus.w),
        .q     (hist)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_next;
            fill_q  <= fill_next;
        end
    end

    // Match is judged on the post-shift view of history and fill.
    always_comb begin
        state_next = state_q;
        fill_next  = fill_q;
        fill_post  = fill_q;
        hist_post  = {hist[PATTERN_W-2:0], bus.w};
        match      = 1'b0;
        if (bus.clear) begin
            fill_next  = '0;
            state_next = FILL;
        end else if (bus.en) begin
            fill_post = (state_q == ARMED) ? FILL_MAX : fill_q + 1'b1;
            match     = (hist_post == pat_q) && (fill_post == FILL_MAX);
            if (match && (bus.overlap == OVERLAP_OFF)) begin
                fill_next = '0;
            end else begin
                fill_next = fill_post;
            end
            state_next = (fill_next == FILL_MAX) ? ARMED : FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= PATTERN_RST;
            cnt_q <= '0;
            out_q <= 1'b0;
        end else if (bus.clear) begin
            pat_q <= bus.pattern;
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            out_q <= match;
            if (match && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.out         = out_q;
    assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: vector table plus reset/saturation sequences.
module tb_seq_detect_param;

    logic clk;
    logic rst_n;

    seq_detect_param_if #(.PATTERN_W(4), .COUNT_W(8)) bus_a ();
    seq_detect_param_if #(.PATTERN_W(4), .COUNT_W(2)) bus_b ();

    seq_detect_param #(.PATTERN_W(4), .COUNT_W(8), .PATTERN_RST(4'b1011)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    seq_detect_param #(.PATTERN_W(4), .COUNT_W(2), .PATTERN_RST(4'b1011)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       en;
        logic       w;
        logic       clear;
        logic       overlap;
        logic [3:0] pattern;
        logic       exp_out;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    function automatic void add(string name, logic en, logic w, logic clear, logic overlap,
                                logic [3:0] pattern, logic exp_out, logic [7:0] exp_cnt);
        vec_t v;
        v.name = name; v.en = en; v.w = w; v.clear = clear; v.overlap = overlap;
        v.pattern = pattern; v.exp_out = exp_out; v.exp_cnt = exp_cnt;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic en, logic w, logic clear, logic overlap, logic [3:0] pattern);
        bus_a.en = en; bus_a.w = w; bus_a.clear = clear; bus_a.overlap = overlap; bus_a.pattern = pattern;
        bus_b.en = en; bus_b.w = w; bus_b.clear = clear; bus_b.overlap = overlap; bus_b.pattern = pattern;
    endtask

    task automatic step(logic en, logic w, logic clear, logic overlap, logic [3:0] pattern);
        drive(en, w, clear, overlap, pattern);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

        // Reset value of the pattern register is exercised first (no clear, port differs).
        add("rst_pat_b1", 1, 1, 0, 1, 4'b0000, 0, 0);
        add("rst_pat_b2", 1, 0, 0, 1, 4'b0000, 0, 0);
        add("rst_pat_b3", 1, 1, 0, 1, 4'b0000, 0, 0);
        add("rst_pat_b4", 1, 1, 0, 1, 4'b0000, 1, 1);
        // Scenario 1: overlapping 1011 on 1,0,1,1,0,1,1
        add("s1_clear",   1, 1, 1, 1, 4'b1011, 0, 0);
        add("s1_b1",      1, 1, 0, 1, 4'b1011, 0, 0);
        add("s1_b2",      1, 0, 0, 1, 4'b1011, 0, 0);
        add("s1_b3",      1, 1, 0, 1, 4'b1011, 0, 0);
        add("s1_b4",      1, 1, 0, 1, 4'b1011, 1, 1);
        add("s1_b5",      1, 0, 0, 1, 4'b1011, 0, 1);
        add("s1_b6",      1, 1, 0, 1, 4'b1011, 0, 1);
        add("s1_b7",      1, 1, 0, 1, 4'b1011, 1, 2);
        // Scenario 2: same stream, non-overlapping
        add("s2_clear",   1, 1, 1, 0, 4'b1011, 0, 0);
        add("s2_b1",      1, 1, 0, 0, 4'b1011, 0, 0);
        add("s2_b2",      1, 0, 0, 0, 4'b1011, 0, 0);
        add("s2_b3",      1, 1, 0, 0, 4'b1011, 0, 0);
        add("s2_b4",      1, 1, 0, 0, 4'b1011, 1, 1);
        add("s2_b5",      1, 0, 0, 0, 4'b1011, 0, 1);
        add("s2_b6",      1, 1, 0, 0, 4'b1011, 0, 1);
        add("s2_b7",      1, 1, 0, 0, 4'b1011, 0, 1);
        add("s2_b8",      1, 1, 0, 0, 4'b1011, 0, 1);
        // Scenario 3: enable gap with w toggling
        add("s3_clear",   1, 0, 1, 1, 4'b1011, 0, 0);
        add("s3_b1",      1, 1, 0, 1, 4'b1011, 0, 0);
        add("s3_b2",      1, 0, 0, 1, 4'b1011, 0, 0);
        add("s3_b3",      1, 1, 0, 1, 4'b1011, 0, 0);
        add("s3_gap1",    0, 0, 0, 1, 4'b1011, 0, 0);
        add("s3_gap2",    0, 1, 0, 1, 4'b1011, 0, 0);
        add("s3_gap3",    0, 0, 0, 1, 4'b1011, 0, 0);
        add("s3_b4",      1, 1, 0, 1, 4'b1011, 1, 1);
        // Scenario 6: clear overrides en and loads 0110
        add("s6_clear",   1, 1, 1, 1, 4'b0110, 0, 0);
        add("s6_b1",      1, 0, 0, 1, 4'b0110, 0, 0);
        add("s6_b2",      1, 1, 0, 1, 4'b0110, 0, 0);
        add("s6_b3",      1, 1, 0, 1, 4'b0110, 0, 0);
        add("s6_b4",      1, 0, 0, 1, 4'b0110, 1, 1);
        // Port change without clear must not alter the latched pattern
        add("latch_b1",   1, 0, 0, 1, 4'b1011, 0, 1);
        add("latch_b2",   1, 1, 0, 1, 4'b1011, 0, 1);
        add("latch_b3",   1, 1, 0, 1, 4'b1011, 0, 1);
        add("latch_b4",   1, 0, 0, 1, 4'b1011, 1, 2);
        add("hold_en0",   0, 1, 0, 1, 4'b1011, 0, 2);

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_a", 32'(bus_a.out), 32'd0);
        check("reset_cnt_a", 32'(bus_a.match_count), 32'd0);
        check("reset_cnt_b", 32'(bus_b.match_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].w, vecs[i].clear, vecs[i].overlap, vecs[i].pattern);
            check({vecs[i].name, "_out"}, 32'(bus_a.out), 32'(vecs[i].exp_out));
            check({vecs[i].name, "_cnt"}, 32'(bus_a.match_count), 32'(vecs[i].exp_cnt));
        end

        // Scenario 4: 1111 repeated, 2-bit counter saturates at 3
        step(1, 1, 1, 1, 4'b1111);
        for (int i = 1; i <= 9; i++) begin
            step(1, 1, 0, 1, 4'b1111);
            check($sformatf("s4_out_%0d", i), 32'(bus_b.out), (i >= 4) ? 32'd1 : 32'd0);
            check($sformatf("s4_cnt_%0d", i), 32'(bus_b.match_count),
                  (i < 4) ? 32'd0 : ((i - 3 > 3) ? 32'd3 : 32'(i - 3)));
        end

        // Scenario 5: asynchronous reset mid-sequence discards partial history
        step(1, 1, 1, 1, 4'b1011);
        step(1, 1, 0, 1, 4'b1011);
        step(1, 0, 0, 1, 4'b1011);
        step(1, 1, 0, 1, 4'b1011);
        step(1, 1, 0, 1, 4'b1011);
        check("s5_pre_out", 32'(bus_a.out), 32'd1);
        step(1, 1, 0, 1, 4'b1011);
        step(1, 0, 0, 1, 4'b1011);
        step(1, 1, 0, 1, 4'b1011);
        check("s5_pre_cnt", 32'(bus_a.match_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_async_cnt", 32'(bus_a.match_count), 32'd0);
        check("s5_async_out", 32'(bus_a.out), 32'd0);
        drive(1, 1, 0, 1, 4'b1011);
        repeat (2) @(posedge clk);
        #1;
        check("s5_held_cnt", 32'(bus_a.match_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 1, 4'b1011);
        check("s5_nopulse", 32'(bus_a.out), 32'd0);
        step(1, 0, 0, 1, 4'b1011);
        check("s5_b2_out", 32'(bus_a.out), 32'd0);
        step(1, 1, 0, 1, 4'b1011);
        check("s5_b3_out", 32'(bus_a.out), 32'd0);
        step(1, 1, 0, 1, 4'b1011);
        check("s5_b4_out", 32'(bus_a.out), 32'd1);
        check("s5_b4_cnt", 32'(bus_a.match_count), 32'd1);
        step(0, 0, 0, 1, 4'b1011);
        check("s5_after_out", 32'(bus_a.out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
